// File: rtl/nrd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : nrd_pkg
// Brief  : Shared constants for the non-restoring divider sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package nrd_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ITER    = 2'd1;
   localparam state_t ST_RESTORE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   localparam logic [DEFAULT_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/nrd_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : nrd_addsub
// Brief  : Ripple-carry add/subtract; mode=1 subtracts via inverted b + carry-in.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module nrd_addsub #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_c;

   assign w_bx   = b ^ {WIDTH{mode}};
   assign w_c[0] = mode;

   // The final carry-out is dropped: arithmetic wraps modulo 2^WIDTH.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i] = a[i] ^ w_bx[i] ^ w_c[i];
      if (i < WIDTH - 1) begin : g_carry
         assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
      end
   end

endmodule
`default_nettype wire

// File: rtl/nrd_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : nrd_seq_ctrl
// Brief  : Multi-cycle unsigned non-restoring divider with valid/ready on both sides.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module nrd_seq_ctrl
   import nrd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DBZ_Q    = {WIDTH{DBZ_QUOTIENT[0]}};

   state_t           r_state;
   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;

   logic [WIDTH:0]   w_as_a;
   logic [WIDTH:0]   w_as_b;
   logic [WIDTH:0]   w_as_sum;
   logic             w_as_mode;
   logic [WIDTH:0]   w_a_fix;

   // ITER feeds the shifted {A,Q}; RESTORE feeds A unshifted with a forced add.
   always_comb begin
      w_as_b = {1'b0, r_m};
      if (r_state == ST_RESTORE) begin
         w_as_a    = r_a;
         w_as_mode = ADD;
      end else begin
         w_as_a    = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
         w_as_mode = r_a[WIDTH] ? ADD : SUB;
      end
   end

   nrd_addsub #(
      .WIDTH (WIDTH + 1)
   ) u_addsub (
      .a    (w_as_a),
      .b    (w_as_b),
      .mode (w_as_mode),
      .sum  (w_as_sum)
   );

   assign w_a_fix = r_a[WIDTH] ? w_as_sum : r_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (divisor != '0) begin
                     r_a     <= '0;
                     r_q     <= dividend;
                     r_m     <= divisor;
                     r_cnt   <= CNT_INIT;
                     r_state <= ST_ITER;
                  end else begin
                     r_quot  <= DBZ_Q;
                     r_rem   <= dividend;
                     r_dbz   <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_ITER: begin
               r_a   <= w_as_sum;
               r_q   <= {r_q[WIDTH-2:0], ~w_as_sum[WIDTH]};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == '0) begin
                  r_state <= ST_RESTORE;
               end
            end
            ST_RESTORE: begin
               r_a     <= w_a_fix;
               r_quot  <= r_q;
               r_rem   <= w_a_fix[WIDTH-1:0];
               r_dbz   <= 1'b0;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign busy        = (r_state != ST_IDLE);
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
